// File: rtl/led_pattern_sequencer_if.sv
// LED sequencer control/display bundle: mode/speed/pause switch inputs in, LED bank out.
// Latency: none of its own; it only groups wires.
// Backpressure: none; the LED outputs are level signals with no handshake.
//   mode  [1:0] pattern select (0 ALT, 1 CHASE, 2 BOUNCE, 3 FILL)
//   speed [1:0] step period = TICK_DIV >> speed
//   pause       freezes prescaler and pattern state
//   LEDG  [7:0] green LEDs (leds[7:0]); LEDR [9:0] red LEDs (leds[17:8])
interface led_pattern_sequencer_if;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       pause;
    logic [7:0] LEDG;
    logic [9:0] LEDR;

    // master: board switches/keys side, which also watches the LEDs
    modport master (output mode, output speed, output pause, input LEDG, input LEDR);
    // slave: the sequencer itself
    modport slave  (input mode, input speed, input pause, output LEDG, output LEDR);
endinterface

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: divides CLOCK_50 into a step tick and drives ALT/CHASE/BOUNCE/FILL patterns.
// Latency: LEDs are a combinational decode of registered state; they change on the state-update edge.
// Backpressure: none; pause freezes prescaler and pattern, a mode change restarts the pattern.
//   CLOCK_50  board clock, all state on its rising edge
//   reset     asynchronous, active-high; returns to ALT with odd LEDs lit
//   led_bus   slave modport: mode/speed/pause in, LEDG/LEDR out
//   TICK_DIV  cycles per step at speed 0; must be at least 8 so speed 3 still yields a nonzero limit
module led_pattern_sequencer #(
    parameter int unsigned TICK_DIV = 50000000
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    led_pattern_sequencer_if.slave   led_bus
);

    typedef enum logic [1:0] {
        MODE_ALT    = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // count never exceeds TICK_DIV-1, so CW bits suffice; limit math uses one extra bit
    localparam int          CW  = $clog2(TICK_DIV);
    localparam logic [CW:0] DIV = (CW+1)'(TICK_DIV);

    logic [CW-1:0] count_q, count_d;
    mode_e         mode_q,  mode_d;
    logic          ph_q,    ph_d;
    logic [4:0]    pos_q,   pos_d;
    dir_e          dir_q,   dir_d;

    mode_e         mode_in;
    logic [CW:0]   limit_m1;
    logic          tick;
    logic [17:0]   leds;

    assign mode_in  = mode_e'(led_bus.mode);
    assign limit_m1 = (DIV >> led_bus.speed) - (CW+1)'(1);
    // ">=" rather than "==" so a speed increase below the current count ticks at once
    assign tick     = !led_bus.pause && ({1'b0, count_q} >= limit_m1);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            mode_q  <= MODE_ALT;
            ph_q    <= 1'b0;
            pos_q   <= '0;
            dir_q   <= DIR_UP;
        end else begin
            count_q <= count_d;
            mode_q  <= mode_d;
            ph_q    <= ph_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        count_d = count_q;
        mode_d  = mode_q;
        ph_d    = ph_q;
        pos_d   = pos_q;
        dir_d   = dir_q;

        if (mode_in != mode_q) begin
            // restart wins over a coincident tick, and is taken even while paused
            mode_d  = mode_in;
            ph_d    = 1'b0;
            pos_d   = '0;
            dir_d   = DIR_UP;
            count_d = '0;
        end else if (tick) begin
            count_d = '0;
            case (mode_q)
                MODE_ALT:   ph_d = ~ph_q;
                MODE_CHASE: pos_d = (pos_q >= 5'd17) ? 5'd0 : pos_q + 5'd1;
                MODE_BOUNCE: begin
                    // direction flips on the step that lands on an end, so each end shows for one step
                    if (dir_q == DIR_UP) begin
                        pos_d = pos_q + 5'd1;
                        if (pos_q >= 5'd16) dir_d = DIR_DOWN;
                    end else begin
                        pos_d = pos_q - 5'd1;
                        if (pos_q <= 5'd1) dir_d = DIR_UP;
                    end
                end
                MODE_FILL:  pos_d = (pos_q >= 5'd18) ? 5'd0 : pos_q + 5'd1;
                default:    ph_d = ph_q;
            endcase
        end else if (!led_bus.pause) begin
            count_d = count_q + CW'(1);
        end
    end

    always_comb begin
        leds = '0;
        case (mode_q)
            MODE_ALT:    leds = ph_q ? 18'h15555 : 18'h2AAAA;
            MODE_CHASE,
            MODE_BOUNCE: leds = 18'd1 << pos_q;
            // pos lowest LEDs lit; pos=18 lights all of them
            MODE_FILL:   leds = 18'((19'd1 << pos_q) - 19'd1);
            default:     leds = '0;
        endcase
    end

    assign led_bus.LEDG = leds[7:0];
    assign led_bus.LEDR = leds[17:8];

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Sequencer for the board LED bank (8 green + 10 red LEDs) on the 50 MHz board clock. It divides the clock into a step tick and drives one of four selectable light patterns: alternating blink, chase, bounce, or bar fill. Mode, speed and pause come from board switches or keys. It replaces free-running per-design blink counters and becomes the single owner of LEDG/LEDR.

## Interface
- TICK_DIV, 50000000, clock cycles per pattern step at speed 0 (1 s at 50 MHz); must be ≥ 8
- CLOCK_50  in  1  board clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- mode  in  2  pattern select: 0 ALT, 1 CHASE, 2 BOUNCE, 3 FILL
- speed  in  2  step period = TICK_DIV >> speed cycles
- pause  in  1  high freezes prescaler and pattern state
- LEDG  out  8  green LEDs, = leds[7:0]
- LEDR  out  10  red LEDs, = leds[17:8]

## Operation
- Internal 18-bit view leds[17:0]; outputs are a combinational decode of registered state (mode_q, ph, pos[4:0], dir, count).
- Prescaler:
  - limit = TICK_DIV >> speed.
  - tick = !pause && count >= limit-1; on tick, count ← 0.
  - Otherwise, if !pause, count ← count+1. Pause holds count.
- Patterns (state advances only on tick):
  - ALT: leds[even] = ph, leds[odd] = ~ph; ph toggles each tick.
  - CHASE: leds = 1 << pos; pos 0→17, then wraps 17→0.
  - BOUNCE: leds = 1 << pos. dir up: pos+1; at pos 17 dir ← down, next tick pos 16. dir down: pos−1; at pos 0 dir ← up, next tick pos 1.
  - FILL: leds[i] = (i < pos); pos 0→18, then 18→0 (all off).
- Mode change:
  - When mode ≠ mode_q (sampled every cycle, regardless of pause), on that edge: mode_q ← mode, ph ← 0, pos ← 0, dir ← up, count ← 0.
  - Mode change has priority over a coincident tick; that tick is discarded.
- Speed change takes no restart. If count ≥ new limit−1, the next unpaused cycle ticks.

## Timing
- Reset values:
  - count 0, mode_q 0, ph 0, pos 0, dir up.
  - LEDG = 8'hAA, LEDR = 10'h2AA (ALT, odd LEDs lit).
- If the mode input ≠ 0 at reset release, the restart to that mode happens on the first edge after release.
- First tick: limit cycles after reset release, or after the restart edge. Outputs change on the same edge the state updates; no extra output register.
- Steady state: exactly one state step per limit cycles while unpaused. speed=3 with TICK_DIV=8 gives a step every cycle.
- Pause asserted on the cycle a tick would occur suppresses that tick. After deassertion, counting resumes from the held count.
- Reset asserted mid-pattern returns immediately (asynchronously) to the reset values.
- pos never exceeds 17 in CHASE/BOUNCE, or 18 in FILL. A mode change always clears pos, so no out-of-range state carries across modes.

## Test plan
All scenarios use TICK_DIV=8.
- **Reset/ALT:** assert reset, release with mode=0, speed=0 → LEDG=AA, LEDR=2AA; after 8 cycles LEDG=55, LEDR=155; after 16 cycles back to AA/2AA.
- **CHASE wrap:** mode=1, speed=0.
  - Immediately after restart, LEDG=01.
  - After 17 ticks (136 cycles), LEDR=200, LEDG=00.
  - Tick 18: LEDG=01.
- **BOUNCE turn:** mode=2, speed=3 (tick every cycle) → pos sequence 0,1,…,17,16,…,0,1; LEDR=200 for exactly one cycle at the top.
- **FILL wrap:**
  - mode=3, speed=1 (step every 4 cycles).
  - After 18 ticks, LEDG=FF, LEDR=3FF.
  - Tick 19: all off.
- **Pause and mode priority:**
  - Pause for 20 cycles mid-CHASE → outputs and count frozen. Resume: the next step comes after the remaining count cycles.
  - Switch mode to 0 on a tick cycle → restart with AA/2AA, no pattern step.
  - Assert reset mid-FILL → AA/2AA immediately.
